// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: WB has priority, long-latency results queue and drain into idle WB slots.
// Optional starvation guard enabled by defining RFARB_STARVE_GUARD_EN.
module regfile_wr_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_we,
    input  logic [4:0]              wb_waddr,
    input  logic [31:0]             wb_wdata,
    input  logic                    lu_valid,
    input  logic [4:0]              lu_waddr,
    input  logic [31:0]             lu_wdata,
    output logic                    lu_ready,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    input  logic [4:0]              r1,
    input  logic                    r1e,
    input  logic [4:0]              r2,
    input  logic                    r2e,
    output logic                    stall_req,
    output logic                    starve_stall,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] sq_q, sq_d;
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    logic             full, wb_hit, pop, enq;
    logic [DEPTH-1:0] valid, live;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        wb_hit   = wb_we && (wb_waddr != 5'd0);
        lu_ready = !rst && !full;
        pop      = !rst && !wb_we && (count_q != '0);
        enq      = !rst && lu_valid && !full && (lu_waddr != 5'd0);
        valid    = '0;
        live     = '0;
        sq_d     = sq_q;
        for (int i = 0; i < DEPTH; i++) begin
            // entry i is occupied when its distance from the read pointer is below the count
            valid[i] = CW'(PW'(PW'(i) - rd_ptr_q)) < count_q;
            live[i]  = valid[i] && !sq_q[i] && !(pop && (PW'(i) == rd_ptr_q));
            if (wb_hit && valid[i] && (addr_q[i] == wb_waddr)) sq_d[i] = 1'b1;
        end
        if (enq) sq_d[wr_ptr_q] = wb_hit && (lu_waddr == wb_waddr);
        count_d = count_q + CW'(enq) - CW'(pop);
    end

    always_comb begin
        stall_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && r1e && (r1 != 5'd0) && (addr_q[i] == r1)) stall_req = 1'b1;
            if (live[i] && r2e && (r2 != 5'd0) && (addr_q[i] == r2)) stall_req = 1'b1;
        end
        if (rst) stall_req = 1'b0;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (wb_we) begin
                rf_we    = wb_hit;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (count_q != '0) begin
                rf_we    = !sq_q[rd_ptr_q];
                rf_waddr = addr_q[rd_ptr_q];
                rf_wdata = data_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            sq_q    <= sq_d;
            count_q <= count_d;
            if (enq) begin
                addr_q[wr_ptr_q] <= lu_waddr;
                data_q[wr_ptr_q] <= lu_wdata;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign q_count = count_q;

`ifdef RFARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_q, wait_d;
    logic          starve_q;

    always_comb begin
        wait_d = wait_q;
        if (pop || (count_q == '0)) wait_d = '0;
        else if (wb_we && (wait_q != WW'(MAX_WAIT))) wait_d = wait_q + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= (wait_d == WW'(MAX_WAIT));
        end
    end

    assign starve_stall = starve_q;
`else
    assign starve_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a queue model of pending writes is checked against the DUT every cycle.
module tb_regfile_wr_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0, lu_valid = 1'b0;
    logic [4:0]  wb_waddr = '0, lu_waddr = '0, r1 = '0, r2 = '0;
    logic [31:0] wb_wdata = '0, lu_wdata = '0;
    logic        r1e = 1'b0, r2e = 1'b0;
    logic        lu_ready, rf_we, stall_req, starve_stall;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  q_count;

    regfile_wr_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .r1(r1), .r1e(r1e), .r2(r2), .r2e(r2e),
        .stall_req(stall_req), .starve_stall(starve_stall), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          sq;
    } ent_t;

    ent_t mq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   mwait  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // compare outputs against the model while inputs are stable, then advance the model for the coming edge
    task automatic model_step();
        logic        e_we, e_rdy, e_stall, popping, wb_hit;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        ent_t        t;
        e_we = 1'b0; e_a = '0; e_d = '0; e_stall = 1'b0;
        e_rdy   = !rst && (mq.size() < DEPTH);
        popping = !rst && !wb_we && (mq.size() > 0);
        wb_hit  = wb_we && (wb_waddr != 5'd0);
        if (!rst) begin
            if (wb_we) begin
                e_we = wb_hit; e_a = wb_waddr; e_d = wb_wdata;
            end else if (mq.size() > 0) begin
                e_we = !mq[0].sq; e_a = mq[0].a; e_d = mq[0].d;
            end
            for (int i = 0; i < mq.size(); i++) begin
                if (!(i == 0 && popping) && !mq[i].sq) begin
                    if (r1e && r1 != 5'd0 && mq[i].a == r1) e_stall = 1'b1;
                    if (r2e && r2 != 5'd0 && mq[i].a == r2) e_stall = 1'b1;
                end
            end
        end
        check("rf_we", 32'(rf_we), 32'(e_we));
        check("rf_waddr", 32'(rf_waddr), 32'(e_a));
        check("rf_wdata", rf_wdata, e_d);
        check("lu_ready", 32'(lu_ready), 32'(e_rdy));
        check("stall_req", 32'(stall_req), 32'(e_stall));
        check("q_count", 32'(q_count), mq.size());
`ifdef RFARB_STARVE_GUARD_EN
        check("starve_stall", 32'(starve_stall), 32'(mwait == MAX_WAIT));
`else
        check("starve_stall", 32'(starve_stall), 32'd0);
`endif
        if (rst) begin
            mq.delete();
            mwait = 0;
        end else begin
            if (popping || mq.size() == 0) mwait = 0;
            else if (wb_we && mwait < MAX_WAIT) mwait++;
            if (wb_hit) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].a == wb_waddr) begin
                        t = mq[i]; t.sq = 1'b1; mq[i] = t;
                    end
                end
            end
            if (popping) void'(mq.pop_front());
            if (lu_valid && e_rdy && lu_waddr != 5'd0) begin
                t.a = lu_waddr; t.d = lu_wdata; t.sq = wb_hit && (lu_waddr == wb_waddr);
                mq.push_back(t);
            end
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
        wb_we = we; wb_waddr = wa; wb_wdata = wd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    endtask

    initial begin
        // reset with a pending lu request
        rst = 1'b1;
        drv(0, 0, 0, 1, 5'd2, 32'h1234);
        cyc(2);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        cyc(1);

        // single lu write drains into an idle WB slot
        drv(0, 0, 0, 1, 5'd3, 32'hDEADBEEF); cyc(1);
        drv(0, 0, 0, 0, 0, 0);               cyc(2);

        // fill the FIFO while WB is busy, then drain in order
        drv(1, 5'd1, 32'hA1, 1, 5'd4, 32'h44); cyc(1);
        drv(1, 5'd2, 32'hA2, 1, 5'd5, 32'h55); cyc(1);
        drv(1, 5'd9, 32'hA3, 1, 5'd9, 32'h99); cyc(2);
        drv(0, 0, 0, 0, 0, 0);                 cyc(3);

        // WAW squash of a queued entry
        drv(1, 5'd1, 32'hB1, 1, 5'd6, 32'h11); cyc(1);
        drv(1, 5'd6, 32'h22, 0, 0, 0);         cyc(1);
        drv(0, 0, 0, 0, 0, 0);                 cyc(2);

        // WAW squash of a same-cycle incoming entry, and lu write to r0 dropped
        drv(1, 5'd10, 32'hC0, 1, 5'd10, 32'hC1); cyc(1);
        drv(0, 0, 0, 1, 5'd0, 32'hC2);           cyc(1);
        drv(0, 0, 0, 0, 0, 0);                   cyc(2);

        // RAW hazard reporting
        drv(1, 5'd1, 32'hD1, 1, 5'd7, 32'h77); cyc(1);
        drv(1, 5'd1, 32'hD2, 0, 0, 0);
        r1 = 5'd7; r1e = 1'b1; cyc(1);
        r1e = 1'b0;            cyc(1);
        r1 = 5'd0; r1e = 1'b1; cyc(1);
        r1e = 1'b0; r2 = 5'd7; r2e = 1'b1; cyc(1);
        r2e = 1'b0; r1 = 5'd7; r1e = 1'b1;
        drv(0, 0, 0, 0, 0, 0); cyc(1);
        r1e = 1'b0; r1 = 5'd0; cyc(1);

        // long blocked head exercises the starvation guard
        drv(1, 5'd1, 32'hE0, 1, 5'd8, 32'h88); cyc(1);
        drv(1, 5'd1, 32'hE1, 0, 0, 0);         cyc(11);
        drv(0, 0, 0, 0, 0, 0);                 cyc(3);

        // reset mid-operation discards queued results
        drv(1, 5'd1, 32'hF0, 1, 5'd11, 32'hF1); cyc(1);
        drv(1, 5'd1, 32'hF2, 1, 5'd12, 32'hF3); cyc(1);
        rst = 1'b1; drv(0, 0, 0, 0, 0, 0); cyc(1);
        rst = 1'b0; cyc(2);

        // random traffic over a small address range to provoke collisions
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            drv(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
            r1 = 5'($urandom_range(0, 7)); r1e = 1'($urandom_range(0, 1));
            r2 = 5'($urandom_range(0, 7)); r2e = 1'($urandom_range(0, 1));
            if (k % 40 == 39) wb_we = 1'b0;
            cyc(1);
        end
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0); r1e = 1'b0; r2e = 1'b0;
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the register file's single write port between the pipeline WB stage and a long-latency unit (mul/div, multi-cycle load). WB always has priority. Long-latency results wait in a small FIFO and drain into idle WB cycles. The block also reports read-after-write hazards against queued results to the stall controller, and squashes stale queued writes (WAW).

Parameters:
DEPTH, 2, FIFO entries for long-latency results; power of 2, >=2
MAX_WAIT, 8, cycles the FIFO head may be blocked before starvation stall (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wb_we  in  1  WB stage write request
wb_waddr  in  5  WB destination register
wb_wdata  in  32  WB write data
lu_valid  in  1  long-latency result valid
lu_waddr  in  5  long-latency destination register
lu_wdata  in  32  long-latency result data
lu_ready  out  1  FIFO can accept; handshake on lu_valid&&lu_ready
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile write address
rf_wdata  out  32  regfile write data
r1  in  5  ID read address 1
r1e  in  1  read 1 enable
r2  in  5  ID read address 2
r2e  in  1  read 2 enable
stall_req  out  1  RAW hazard on a queued result; ID must stall
starve_stall  out  1  request pipeline bubble so the FIFO can drain
q_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, pointers/counters/squash bits cleared, starve_stall=0.
- While rst=1, combinational outputs forced: rf_we=0, rf_waddr=0, rf_wdata=0, lu_ready=0, stall_req=0.
- Reset mid-operation discards all queued results without writing them.
- Write port is combinational, 0-cycle latency, so the regfile's same-cycle write bypass still covers WB.
- wb_we=1: rf_* = wb_*. No pop.
- wb_we=0 and q_count>0: rf_* = FIFO head; head popped at posedge. A squashed head is popped with rf_we=0.
- Otherwise rf_we=0, rf_waddr=0, rf_wdata=0.
- Address 0 writes: WB to r0 gives rf_we=0. Accepted lu writes to r0 are dropped, not enqueued.
- lu_ready = (q_count < DEPTH), from registered state only; no combinational path from wb_we or pop.
  - When full, no enqueue even if a pop happens the same cycle.
- Simultaneous enqueue and pop: allowed when not full; q_count unchanged.
- Pointers wrap modulo DEPTH.
- WAW squash: when wb_we=1 and wb_waddr!=0, mark every valid entry with matching waddr squashed, plus a same-cycle incoming lu entry to that address. The WB instruction is the younger one.
- stall_req = (r1e && r1!=0 && r1 matches a valid, unsquashed entry) || (same for r2/r2e).
  - Excludes the head being popped this cycle, which the regfile bypass covers.
  - Excludes the same-cycle incoming lu entry; upstream issue logic covers that window.
- q_count registered, updates at posedge.

Optional Feature:
RFARB_STARVE_GUARD_EN
- Defined:
  - wait_cnt increments each cycle q_count>0 && wb_we=1 (head blocked), saturating at MAX_WAIT.
  - wait_cnt clears on pop or when empty.
  - starve_stall is a registered output, 1 while wait_cnt==MAX_WAIT.
  - The pipeline then presents wb_we=0 for at least one cycle; the head pops and wait_cnt clears.
  - If wb_we=1 arrives anyway, WB still wins and starve_stall stays high.
- Undefined: starve_stall tied 0, no wait counter.

Test Plan:
1. rst=1 for 2 cycles with lu_valid=1 -> rf_we=0, lu_ready=0, q_count=0. After release, lu_ready=1.
2. lu write r3=0xDEADBEEF, wb_we=0 next cycle -> q_count=1 for one cycle, then rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF, q_count=0.
3. Enqueue r4, r5 (full, DEPTH=2) while wb_we=1 continuously -> lu_ready=0; WB data on port each cycle; further lu_valid not accepted. Drop wb_we -> r4 then r5 written in order, lu_ready=1 after first pop.
4. Queue r6=0x11; WB writes r6=0x22 -> entry squashed. Drain cycle gives rf_we=0, and r6 keeps 0x22.
5. Queue r7; ID r1=7, r1e=1 -> stall_req=1. r1e=0 or r1=0 -> stall_req=0. Drain cycle with r1=7 -> stall_req=0.
6. RFARB_STARVE_GUARD_EN, MAX_WAIT=8: queue r8, hold wb_we=1 -> starve_stall=1 after 8 blocked cycles. One wb_we=0 cycle -> r8 written, starve_stall=0 next cycle.
